dram_burst_model: RTL and testbench



---
 rtl/dram_burst_model.sv | 146 ++++++++++++++
 tb/tb_dram_burst_model.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_model.sv
// Cycle-accurate burst DRAM model: valid/ready requests, handshaked write beats, fixed-latency reads.
// Optional beat/request counters are compiled in with `define DRAM_MODEL_STATS_EN.
module dram_burst_model #(
  parameter int    AWIDTH       = 10,
  parameter int    DWIDTH       = 80,
  parameter int    LEN_WIDTH    = 4,
  parameter int    READ_LATENCY = 3,
  parameter string INIT_FILE    = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AWIDTH-1:0]    req_addr,
  input  logic [LEN_WIDTH-1:0] req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DWIDTH-1:0]    wr_data,
  output logic                 rd_valid,
  output logic [DWIDTH-1:0]    rd_data,
  output logic                 rd_last,
`ifdef DRAM_MODEL_STATS_EN
  output logic [31:0]          rd_beat_count,
  output logic [31:0]          wr_beat_count,
  output logic [31:0]          req_count,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN, WR_BEATS} state_t;

  localparam logic [AWIDTH-1:0]  ADDR_ONE = 1;
  localparam logic [LEN_WIDTH:0] BEAT_ONE = 1;

  state_t               state;
  logic [AWIDTH-1:0]    addr;
  logic [LEN_WIDTH:0]   beats_left;
  logic [DWIDTH-1:0]    mem [0:(1<<AWIDTH)-1];

  logic [READ_LATENCY:1]             vld_pipe;
  logic [READ_LATENCY:1]             last_pipe;
  logic [READ_LATENCY:1][DWIDTH-1:0] data_pipe;

  logic req_hs, wr_acc, issue, final_beat;

  assign req_hs     = req_valid & req_ready;
  assign wr_acc     = wr_valid & wr_ready;
  assign issue      = (state == RD_ISSUE);
  assign final_beat = (beats_left == BEAT_ONE);

  // Storage is deliberately outside the reset domain: reset never clears contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      beats_left <= '0;
      req_ready  <= 1'b0;
      wr_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            addr       <= req_addr;
            beats_left <= {1'b0, req_len} + BEAT_ONE;
            req_ready  <= 1'b0;
            if (req_we) begin
              state    <= WR_BEATS;
              wr_ready <= 1'b1;
            end else begin
              state    <= RD_ISSUE;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD_ISSUE: begin
          addr       <= addr + ADDR_ONE;
          beats_left <= beats_left - BEAT_ONE;
          if (final_beat) state <= RD_DRAIN;
        end
        RD_DRAIN: begin
          // Only one burst is ever in flight, so its last beat leaving empties the pipe.
          if (vld_pipe[READ_LATENCY] && last_pipe[READ_LATENCY]) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        WR_BEATS: begin
          if (wr_valid) begin
            addr       <= addr + ADDR_ONE;
            beats_left <= beats_left - BEAT_ONE;
            if (final_beat) begin
              state     <= IDLE;
              wr_ready  <= 1'b0;
              req_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      last_pipe[1] <= issue & final_beat;
      data_pipe[1] <= issue ? mem[addr] : '0;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign rd_valid = vld_pipe[READ_LATENCY];
  assign rd_last  = last_pipe[READ_LATENCY];
  assign rd_data  = data_pipe[READ_LATENCY];
  assign busy     = (state != IDLE) || (|vld_pipe);

`ifdef DRAM_MODEL_STATS_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_beat_count <= '0;
      wr_beat_count <= '0;
      req_count     <= '0;
    end else begin
      if (rd_valid && rd_beat_count != '1) rd_beat_count <= rd_beat_count + 32'd1;
      if (wr_acc && wr_beat_count != '1)   wr_beat_count <= wr_beat_count + 32'd1;
      if (req_hs && req_count != '1)       req_count     <= req_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_burst_model.sv
// Randomized bench for dram_burst_model against an array/queue reference of the burst rules.
module tb_dram_burst_model;
  localparam int AW = 10, DW = 80, LW = 4, LAT = 4, DEPTH = 1 << AW;

  logic          clk = 1'b0, reset = 1'b1;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, rd_last, busy;
`ifdef DRAM_MODEL_STATS_EN
  logic [31:0]   rd_beat_count, wr_beat_count, req_count;
`endif

  dram_burst_model #(.AWIDTH(AW), .DWIDTH(DW), .LEN_WIDTH(LW), .READ_LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
`ifdef DRAM_MODEL_STATS_EN
    .rd_beat_count(rd_beat_count), .wr_beat_count(wr_beat_count), .req_count(req_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            known   [DEPTH];

  typedef struct {int cyc; logic [DW-1:0] data; bit last;} beat_t;
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every rd_valid beat must match the head of the expected-beat queue.
  always @(negedge clk) begin
    beat_t e;
    if (!reset && rd_valid) begin
      if (exp_q.size() == 0) chk("rd_spurious", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_data", rd_data, e.data);
        chk("rd_last", rd_last, e.last);
      end
    end
  end

  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [LW-1:0] len, output int t);
    int k = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = len;
    while (!req_ready && k < 100) begin @(posedge clk); #1; k++; end
    chk("req_accept", req_ready, 1);
    t = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [LW-1:0] len);
    int t;
    int n = int'(len) + 1;
    do_req(1'b0, a, len, t);
    for (int i = 0; i < n; i++) begin
      beat_t e;
      e.cyc  = t + 1 + LAT + i;
      e.data = ref_mem[(int'(a) + i) % DEPTH];
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
    while (cyc < t + LAT + n) begin @(posedge clk); #1; end
    chk("rd_last_cycle_busy_rdy", {busy, req_ready}, 2'b10);
    @(posedge clk); #1;
    chk("rd_ready_back", {busy, req_ready}, 2'b01);
    chk("rd_beats_seen", exp_q.size(), 0);
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input logic [LW-1:0] len, input bit fixed,
                          input logic [DW-1:0] base, input int stall_at, input int stall_n, input bit rnd);
    int t;
    int n = int'(len) + 1;
    logic [DW-1:0] d;
    do_req(1'b1, a, len, t);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        wr_valid = 1'b0;
        repeat (stall_n) begin @(posedge clk); #1; chk("stall_req_ready", req_ready, 0); end
      end
      while (rnd && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstall_req_ready", req_ready, 0);
      end
      d = fixed ? base + DW'(i) : DW'({$urandom, $urandom, $urandom});
      wr_valid = 1'b1; wr_data = d;
      chk("wr_ready", wr_ready, 1);
      @(posedge clk); #1;
      ref_mem[(int'(a) + i) % DEPTH] = d;
      known[(int'(a) + i) % DEPTH]   = 1'b1;
    end
    chk("wr_done_rdy", {wr_ready, req_ready}, 2'b01);
    // Junk beats after the burst must be ignored.
    wr_data = '1;
    repeat (2) @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit we;
    logic [AW-1:0] a;
    logic [LW-1:0] len;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {req_ready, wr_ready, rd_valid, rd_last, busy}, 5'b0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", {busy, req_ready}, 2'b01);

    wr_burst(10'h010, 4'd3, 1'b1, 80'hA0, -1, 0, 1'b0);
    rd_burst(10'h010, 4'd3);

    wr_burst(10'h005, 4'd0, 1'b1, 80'h55, -1, 0, 1'b0);
    rd_burst(10'h005, 4'd0);

    wr_burst(10'h3FE, 4'd3, 1'b1, 80'h1, -1, 0, 1'b0);
    rd_burst(10'h3FE, 4'd3);

    wr_burst(10'h103, 4'd0, 1'b1, 80'hDEAD, -1, 0, 1'b0);
    wr_burst(10'h100, 4'd2, 1'b0, '0, 1, 5, 1'b0);
    rd_burst(10'h100, 4'd3);

    for (int r = 0; r < 40; r++) begin
      we  = 1'($urandom_range(0, 1));
      a   = AW'($urandom);
      len = LW'($urandom);
      if (!we)
        for (int i = 0; i <= int'(len); i++)
          if (!known[(int'(a) + i) % DEPTH]) we = 1'b1;
      if (we) wr_burst(a, len, 1'b0, '0, -1, 0, 1'b1);
      else    rd_burst(a, len);
    end

    // Reset in the middle of a long read: pending beats vanish, storage survives.
    wr_burst(10'h040, 4'd7, 1'b0, '0, -1, 0, 1'b0);
    do_req(1'b0, 10'h040, 4'd7, t);
    for (int i = 0; i < 8; i++) begin
      beat_t e;
      e.cyc = t + 1 + LAT + i; e.data = ref_mem[16'h40 + i]; e.last = (i == 7);
      exp_q.push_back(e);
    end
    while (cyc < t + LAT + 2) begin @(posedge clk); #1; end
    chk("mid_rd_valid", rd_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_outs", {rd_valid, busy, req_ready, wr_ready}, 4'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_release", {busy, req_ready}, 2'b01);
    rd_burst(10'h040, 4'd7);

`ifdef DRAM_MODEL_STATS_EN
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("stats_rst", {rd_beat_count, wr_beat_count, req_count}, 96'h0);
`endif
    wr_burst(10'h020, 4'd1, 1'b0, '0, -1, 0, 1'b0);
    rd_burst(10'h010, 4'd3);
    rd_burst(10'h005, 4'd0);
`ifdef DRAM_MODEL_STATS_EN
    chk("stats_rd_beats", rd_beat_count, 5);
    chk("stats_wr_beats", wr_beat_count, 2);
    chk("stats_req", req_count, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
